// File: rtl/data_bus_arbiter_pkg.sv
// Shared definitions for the MiniRISC data-bus arbiter: FSM state encodings,
// master IDs and the round-robin pick used at arbitration time.
package data_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        BUS_IDLE   = 2'd0,
        BUS_WAIT   = 2'd1,
        BUS_ACCESS = 2'd2
    } bus_state_t;

    localparam logic BUS_MASTER_CPU = 1'b0;
    localparam logic BUS_MASTER_DMA = 1'b1;

    localparam int CNT_W = 4;

    // On a tie the master that was not served last wins.
    function automatic logic pick_owner(input logic cpu_req, input logic dma_req,
                                        input logic last);
        if (cpu_req && dma_req) return ~last;
        else if (dma_req)       return BUS_MASTER_DMA;
        else                    return BUS_MASTER_CPU;
    endfunction

endpackage

// File: rtl/data_bus_arbiter_if.sv
// Two-master data-bus handshake plus the shared memory/peripheral bus lines.
interface data_bus_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              cpu_bus_req;
    logic              cpu_wr;
    logic              cpu_rd;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wr_data;
    logic              cpu_bus_grant;

    logic              dma_bus_req;
    logic              dma_wr;
    logic              dma_rd;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wr_data;
    logic              dma_bus_grant;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_wr;
    logic              mem_rd;

    modport master (
        output cpu_bus_req, cpu_wr, cpu_rd, cpu_addr, cpu_wr_data,
        output dma_bus_req, dma_wr, dma_rd, dma_addr, dma_wr_data,
        input  cpu_bus_grant, dma_bus_grant,
        input  mem_addr, mem_wr_data, mem_wr, mem_rd
    );

    modport slave (
        input  cpu_bus_req, cpu_wr, cpu_rd, cpu_addr, cpu_wr_data,
        input  dma_bus_req, dma_wr, dma_rd, dma_addr, dma_wr_data,
        output cpu_bus_grant, dma_bus_grant,
        output mem_addr, mem_wr_data, mem_wr, mem_rd
    );
endinterface

// File: rtl/data_bus_arbiter_bus_wait_counter.sv
// Loadable 4-bit down-counter timing the wait states; saturates at zero.
module bus_wait_counter
    import data_bus_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   cnt <= '0;
        else if (load)             cnt <= load_val;
        else if (en && cnt != '0)  cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/data_bus_arbiter.sv
// Round-robin CPU/DMA data-bus arbiter: arbitrate, wait WAIT_STATES cycles,
// then issue one single-cycle access for the owner.
module data_bus_arbiter
    import data_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic             clk,
    input  logic             rst,
    data_bus_arbiter_if.slave bus
);
    localparam logic [CNT_W-1:0] WAIT_LOAD =
        (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

    bus_state_t state, state_nxt;
    logic       owner, owner_nxt;
    logic       last, last_nxt;
    logic       cnt_load, cnt_en, cnt_zero;

    logic              owner_req, owner_wr, owner_rd;
    logic [ADDR_W-1:0] owner_addr;
    logic [DATA_W-1:0] owner_wr_data;

    assign owner_req     = (owner == BUS_MASTER_DMA) ? bus.dma_bus_req : bus.cpu_bus_req;
    assign owner_wr      = (owner == BUS_MASTER_DMA) ? bus.dma_wr      : bus.cpu_wr;
    assign owner_rd      = (owner == BUS_MASTER_DMA) ? bus.dma_rd      : bus.cpu_rd;
    assign owner_addr    = (owner == BUS_MASTER_DMA) ? bus.dma_addr    : bus.cpu_addr;
    assign owner_wr_data = (owner == BUS_MASTER_DMA) ? bus.dma_wr_data : bus.cpu_wr_data;

    bus_wait_counter u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (WAIT_LOAD),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BUS_IDLE;
            owner <= BUS_MASTER_CPU;
            last  <= BUS_MASTER_DMA;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            last  <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        case (state)
            BUS_IDLE: begin
                if (bus.cpu_bus_req || bus.dma_bus_req) begin
                    owner_nxt = pick_owner(bus.cpu_bus_req, bus.dma_bus_req, last);
                    if (WAIT_STATES == 0) begin
                        state_nxt = BUS_ACCESS;
                    end else begin
                        state_nxt = BUS_WAIT;
                        cnt_load  = 1'b1;
                    end
                end
            end
            BUS_WAIT: begin
                // A withdrawn request abandons the slot without touching last.
                if (!owner_req)    state_nxt = BUS_IDLE;
                else if (cnt_zero) state_nxt = BUS_ACCESS;
                else               cnt_en    = 1'b1;
            end
            BUS_ACCESS: begin
                state_nxt = BUS_IDLE;
                if (owner_req) last_nxt = owner;
            end
            default: state_nxt = BUS_IDLE;
        endcase
    end

    always_comb begin
        bus.cpu_bus_grant = 1'b0;
        bus.dma_bus_grant = 1'b0;
        bus.mem_wr        = 1'b0;
        bus.mem_rd        = 1'b0;
        if (state == BUS_ACCESS && owner_req) begin
            if (owner == BUS_MASTER_DMA) bus.dma_bus_grant = 1'b1;
            else                         bus.cpu_bus_grant = 1'b1;
            bus.mem_wr = owner_wr;
            bus.mem_rd = owner_rd & ~owner_wr;
        end
    end

    assign bus.mem_addr    = owner_addr;
    assign bus.mem_wr_data = owner_wr_data;
endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: four instances (WAIT_STATES 0..3) share one
// stimulus; a transaction-level model checks every cycle, plus directed cases.
module tb_data_bus_arbiter;
    localparam int NI = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       cpu_req = 0, cpu_wr = 0, cpu_rd = 0;
    logic [7:0] cpu_addr = 0, cpu_wdat = 0;
    logic       dma_req = 0, dma_wr = 0, dma_rd = 0;
    logic [7:0] dma_addr = 0, dma_wdat = 0;

    logic [NI-1:0] o_cg, o_dg, o_mrd, o_mwr, e_cg, e_dg, e_mrd, e_mwr;
    logic [7:0]    o_addr [NI], o_wdat [NI], e_addr [NI], e_wdat [NI];

    int  n_checks = 0;
    int  n_errors = 0;
    bit  model_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : inst
        data_bus_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bif ();
        assign bif.cpu_bus_req = cpu_req;
        assign bif.cpu_wr      = cpu_wr;
        assign bif.cpu_rd      = cpu_rd;
        assign bif.cpu_addr    = cpu_addr;
        assign bif.cpu_wr_data = cpu_wdat;
        assign bif.dma_bus_req = dma_req;
        assign bif.dma_wr      = dma_wr;
        assign bif.dma_rd      = dma_rd;
        assign bif.dma_addr    = dma_addr;
        assign bif.dma_wr_data = dma_wdat;

        data_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(g)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bif)
        );

        assign o_cg[g]   = bif.cpu_bus_grant;
        assign o_dg[g]   = bif.dma_bus_grant;
        assign o_mrd[g]  = bif.mem_rd;
        assign o_mwr[g]  = bif.mem_wr;
        assign o_addr[g] = bif.mem_addr;
        assign o_wdat[g] = bif.mem_wr_data;

        // Model: a slot is "busy" from arbitration until its access cycle,
        // "remain" counts cycles left before that access cycle.
        bit busy, own, lastm;
        int remain;
        wire oreq = own ? dma_req : cpu_req;
        wire owr  = own ? dma_wr  : cpu_wr;
        wire ord  = own ? dma_rd  : cpu_rd;
        wire acc  = busy && (remain == 0) && oreq;

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                busy <= 0; own <= 0; lastm <= 1; remain <= 0;
            end else if (!busy) begin
                if (cpu_req || dma_req) begin
                    own    <= (cpu_req && dma_req) ? !lastm : dma_req;
                    busy   <= 1;
                    remain <= g;
                end
            end else if (remain == 0) begin
                if (oreq) lastm <= own;
                busy <= 0;
            end else if (!oreq) begin
                busy <= 0;
            end else begin
                remain <= remain - 1;
            end
        end

        assign e_cg[g]   = acc && !own;
        assign e_dg[g]   = acc && own;
        assign e_mwr[g]  = acc && owr;
        assign e_mrd[g]  = acc && ord && !owr;
        assign e_addr[g] = own ? dma_addr : cpu_addr;
        assign e_wdat[g] = own ? dma_wdat : cpu_wdat;
    end

    always @(negedge clk) begin
        if (model_en) begin
            for (int g = 0; g < NI; g++) begin
                check($sformatf("model ws%0d cpu_gnt", g), o_cg[g],   e_cg[g]);
                check($sformatf("model ws%0d dma_gnt", g), o_dg[g],   e_dg[g]);
                check($sformatf("model ws%0d mem_rd", g),  o_mrd[g],  e_mrd[g]);
                check($sformatf("model ws%0d mem_wr", g),  o_mwr[g],  e_mwr[g]);
                check($sformatf("model ws%0d addr", g),    o_addr[g], e_addr[g]);
                check($sformatf("model ws%0d wdata", g),   o_wdat[g], e_wdat[g]);
            end
            check("grant overlap", o_cg & o_dg, '0);
        end
    end

    typedef struct {
        logic       rst, creq, crd, cwr;
        logic [7:0] cadr;
        logic       dreq, drd, dwr;
        logic [7:0] dadr, ddat;
        logic       cg, dg, mrd, mwr;
        logic [7:0] madr;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic cq, input logic crd_i,
                                input logic [7:0] ca, input logic dq, input logic dwr_i,
                                input logic [7:0] da, input logic [7:0] dd,
                                input logic cg, input logic dg, input logic mrd,
                                input logic mwr, input logic [7:0] ma);
        vec_t v;
        v.rst = r; v.creq = cq; v.crd = crd_i; v.cwr = 1'b0; v.cadr = ca;
        v.dreq = dq; v.drd = 1'b0; v.dwr = dwr_i; v.dadr = da; v.ddat = dd;
        v.cg = cg; v.dg = dg; v.mrd = mrd; v.mwr = mwr; v.madr = ma;
        return v;
    endfunction

    task automatic clear_inputs();
        cpu_req = 0; cpu_wr = 0; cpu_rd = 0; cpu_addr = 0; cpu_wdat = 8'h3C;
        dma_req = 0; dma_wr = 0; dma_rd = 0; dma_addr = 0; dma_wdat = 0;
    endtask

    // Leaves the bench at posedge+1 of the first post-reset cycle.
    task automatic do_reset();
        clear_inputs();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    vec_t tv[15];

    initial begin
        logic [15:0] cmask, dmask;
        int strobes;

        // WAIT_STATES=1 vectors: CPU read, then tie after reset (CPU, DMA, CPU).
        tv[0]  = mk(1, 0, 0, 8'h80, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h80);
        tv[1]  = mk(0, 1, 1, 8'h80, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h80);
        tv[2]  = mk(0, 1, 1, 8'h80, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h80);
        tv[3]  = mk(0, 1, 1, 8'h80, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 8'h80);
        tv[4]  = mk(0, 0, 1, 8'h80, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h80);
        tv[5]  = mk(1, 0, 0, 8'h11, 0, 0, 8'h22, 8'h5A, 0, 0, 0, 0, 8'h11);
        tv[6]  = mk(0, 1, 1, 8'h11, 1, 1, 8'h22, 8'h5A, 0, 0, 0, 0, 8'h11);
        tv[7]  = mk(0, 1, 1, 8'h11, 1, 1, 8'h22, 8'h5A, 0, 0, 0, 0, 8'h11);
        tv[8]  = mk(0, 1, 1, 8'h11, 1, 1, 8'h22, 8'h5A, 1, 0, 1, 0, 8'h11);
        tv[9]  = mk(0, 1, 1, 8'h11, 1, 1, 8'h22, 8'h5A, 0, 0, 0, 0, 8'h11);
        tv[10] = mk(0, 1, 1, 8'h11, 1, 1, 8'h22, 8'h5A, 0, 0, 0, 0, 8'h22);
        tv[11] = mk(0, 1, 1, 8'h11, 1, 1, 8'h22, 8'h5A, 0, 1, 0, 1, 8'h22);
        tv[12] = mk(0, 1, 1, 8'h11, 1, 1, 8'h22, 8'h5A, 0, 0, 0, 0, 8'h22);
        tv[13] = mk(0, 1, 1, 8'h11, 1, 1, 8'h22, 8'h5A, 0, 0, 0, 0, 8'h11);
        tv[14] = mk(0, 1, 1, 8'h11, 1, 1, 8'h22, 8'h5A, 1, 0, 1, 0, 8'h11);

        clear_inputs();
        #2;
        do_reset();
        model_en = 1;

        for (int i = 0; i < 15; i++) begin
            rst = tv[i].rst;
            cpu_req = tv[i].creq; cpu_rd = tv[i].crd; cpu_wr = tv[i].cwr; cpu_addr = tv[i].cadr;
            dma_req = tv[i].dreq; dma_rd = tv[i].drd; dma_wr = tv[i].dwr;
            dma_addr = tv[i].dadr; dma_wdat = tv[i].ddat;
            @(negedge clk);
            check($sformatf("vec%0d cpu_gnt", i), o_cg[1],   tv[i].cg);
            check($sformatf("vec%0d dma_gnt", i), o_dg[1],   tv[i].dg);
            check($sformatf("vec%0d mem_rd", i),  o_mrd[1],  tv[i].mrd);
            check($sformatf("vec%0d mem_wr", i),  o_mwr[1],  tv[i].mwr);
            check($sformatf("vec%0d mem_addr", i), o_addr[1], tv[i].madr);
            next_cycle();
        end

        // WAIT_STATES=0 DMA write: grant in cycle 1, exactly one strobe.
        do_reset();
        dma_req = 1; dma_wr = 1; dma_addr = 8'h10; dma_wdat = 8'hA5;
        strobes = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("ws0 dma write grant", o_dg[0], 1'b1);
                check("ws0 dma write strobe", o_mwr[0], 1'b1);
                check("ws0 dma write data", o_wdat[0], 8'hA5);
                check("ws0 dma write addr", o_addr[0], 8'h10);
            end
            strobes += int'(o_mwr[0]) + int'(o_mrd[0]);
            next_cycle();
            if (c == 1) dma_req = 0;
        end
        check("ws0 strobe count", strobes, 1);

        // WAIT_STATES=2 persistent DMA, CPU joins mid-burst.
        do_reset();
        dma_req = 1; dma_rd = 1; dma_addr = 8'h44;
        cmask = 0; dmask = 0;
        for (int c = 0; c < 16; c++) begin
            if (c == 5) begin cpu_req = 1; cpu_rd = 1; cpu_addr = 8'h55; end
            @(negedge clk);
            cmask[c] = o_cg[2];
            dmask[c] = o_dg[2];
            next_cycle();
        end
        check("ws2 dma grant cycles", dmask, 16'h8088);
        check("ws2 cpu grant cycles", cmask, 16'h0800);

        // WAIT_STATES=3: CPU drops req in WAIT; DMA req at cycle 3 proves IDLE.
        do_reset();
        cmask = 0; dmask = 0;
        for (int c = 0; c < 10; c++) begin
            if (c == 0) begin cpu_req = 1; cpu_rd = 1; cpu_addr = 8'h66; end
            if (c == 2) cpu_req = 0;
            if (c == 3) begin dma_req = 1; dma_wr = 1; dma_addr = 8'h77; end
            if (c == 8) dma_req = 0;
            @(negedge clk);
            cmask[c] = o_cg[3];
            dmask[c] = o_dg[3];
            next_cycle();
        end
        check("ws3 dropped cpu grant", cmask, 16'h0000);
        check("ws3 dma after drop", dmask, 16'h0080);

        // Reset mid-ACCESS (ws1) and mid-WAIT (ws2); tie afterwards goes to CPU.
        do_reset();
        cpu_req = 1; cpu_rd = 1; cpu_addr = 8'h80;
        for (int c = 0; c < 6; c++) begin
            if (c == 3) begin dma_req = 1; dma_wr = 1; dma_addr = 8'h90; dma_wdat = 8'h12; end
            @(negedge clk);
            if (c == 5) check("ws1 dma grant before reset", o_dg[1], 1'b1);
            if (c < 5) next_cycle();
        end
        #1;
        rst = 1;
        #1;
        check("reset kills ws1 outputs", {o_cg[1], o_dg[1], o_mrd[1], o_mwr[1]}, 4'b0000);
        check("reset kills all grants", {o_cg, o_dg, o_mrd, o_mwr}, '0);
        next_cycle();
        rst = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 2) begin
                check("first tie after reset cpu", o_cg[1], 1'b1);
                check("first tie after reset dma", o_dg[1], 1'b0);
            end
            next_cycle();
        end

        // Random traffic against the model, with occasional resets.
        for (int c = 0; c < 2000; c++) begin
            rst      = ($urandom_range(0, 299) == 0);
            cpu_req  = ($urandom_range(0, 9) < 6);
            dma_req  = ($urandom_range(0, 9) < 6);
            cpu_wr   = 1'($urandom_range(0, 1));
            cpu_rd   = 1'($urandom_range(0, 1));
            dma_wr   = 1'($urandom_range(0, 1));
            dma_rd   = 1'($urandom_range(0, 1));
            cpu_addr = 8'($urandom);
            dma_addr = 8'($urandom);
            cpu_wdat = 8'($urandom);
            dma_wdat = 8'($urandom);
            next_cycle();
        end

        @(negedge clk);
        model_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/data_bus_arbiter.md
Name: data_bus_arbiter

Overview:
- Responder/arbiter end of the MiniRISC data-bus handshake (bus_req / bus_grant with wr/rd strobes).
- Accepts requests from two masters, the CPU and a DMA engine, and arbitrates round-robin.
- Inserts a fixed number of wait states, then performs exactly one single-cycle memory/peripheral access per grant.
- Sits between the masters and the data memory/peripheral bus; drives the shared address, write-data and strobe lines.

Parameters:
- ADDR_W, 8, address width.
- DATA_W, 8, data width.
- WAIT_STATES, 1, wait cycles between arbitration and access; legal range 0..15.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- cpu_bus_req  input  1  CPU requests the bus
- cpu_wr  input  1  CPU write request
- cpu_rd  input  1  CPU read request
- cpu_addr  input  ADDR_W  CPU address
- cpu_wr_data  input  DATA_W  CPU write data
- cpu_bus_grant  output  1  CPU access performed this cycle
- dma_bus_req  input  1  DMA requests the bus
- dma_wr  input  1  DMA write request
- dma_rd  input  1  DMA read request
- dma_addr  input  ADDR_W  DMA address
- dma_wr_data  input  DATA_W  DMA write data
- dma_bus_grant  output  1  DMA access performed this cycle
- mem_addr  output  ADDR_W  bus address
- mem_wr_data  output  DATA_W  bus write data
- mem_wr  output  1  single-cycle write strobe
- mem_rd  output  1  single-cycle read strobe; the owning master samples read data in the grant cycle

Behaviour:
- States: IDLE, WAIT, ACCESS. Registers: state, owner (0=CPU, 1=DMA), last (last served master), 4-bit wait counter.
- Reset (asynchronous, immediate):
  - state=IDLE, owner=CPU, last=DMA (CPU wins the first tie), counter=0.
  - All grants and strobes are 0. An access in progress is abandoned with no strobe.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: that master becomes owner.
  - Both requesting: the master != last becomes owner.
  - On selection: if WAIT_STATES=0 go to ACCESS, else load counter=WAIT_STATES-1 and go to WAIT.
- WAIT:
  - If the owner's req drops: return to IDLE with no strobe and no grant; last is unchanged.
  - Else if counter==0: go to ACCESS; otherwise decrement the counter.
- ACCESS:
  - Outputs: owner's grant=1; mem_wr=owner_wr; mem_rd=owner_rd & ~owner_wr (write wins if both set).
  - If the owner's req is 0 in this cycle, no strobe or grant is issued.
  - Next state is always IDLE; last<=owner when the grant was issued.
- Latency: a req first sampled in IDLE in cycle N gets its grant in cycle N+1+WAIT_STATES.
- Back-to-back: there is always one IDLE cycle between accesses, so a persistent DMA req yields one access per 2+WAIT_STATES cycles.
- Output timing:
  - Grants and strobes are decoded combinationally from state/owner/reqs, glitch-free with respect to state.
  - Never more than one grant per cycle; a grant is never asserted outside ACCESS.
- Address/data mux:
  - mem_addr/mem_wr_data follow the owner's inputs in all states.
  - In IDLE they follow the CPU inputs when owner=CPU.
- Non-owner:
  - A request from the non-owner during WAIT/ACCESS is held off; its grant stays 0 until it wins a later arbitration.
- CPU debug accesses (break-state reads/writes) need no special handling; they are ordinary CPU requests.

Decomposition:
- Shared include file bus_defs.vh holds:
  - state encodings BUS_IDLE=2'd0, BUS_WAIT=2'd1, BUS_ACCESS=2'd2;
  - master IDs BUS_MASTER_CPU=1'b0, BUS_MASTER_DMA=1'b1.
- One sub-module, bus_wait_counter: loadable 4-bit down-counter with load, enable and zero flag.
- Arbitration, FSM and mux stay in data_bus_arbiter.

Test Plan:
- WAIT_STATES=1, CPU read: cpu_rd=1, cpu_addr=8'h80, req at cycle 0 and held -> cpu_bus_grant=1 and mem_rd=1 with mem_addr=8'h80 only in cycle 2; mem_wr=0 throughout.
- WAIT_STATES=0, DMA write: dma_wr_data=8'hA5 to 8'h10 -> dma_bus_grant and mem_wr in cycle 1 with mem_wr_data=8'hA5; exactly one strobe.
- Simultaneous requests after reset, both held -> CPU granted first, then DMA, then CPU; grants never overlap.
- Persistent DMA req with WAIT_STATES=2 -> dma_bus_grant pulses every 4 cycles. A CPU req arriving mid-burst is served at the next arbitration.
- CPU req dropped in WAIT (WAIT_STATES=3, drop at cycle 2) -> no grant and no strobe; FSM back in IDLE at cycle 3.
- rst asserted during WAIT and during ACCESS -> grants and strobes drop to 0 immediately. After release, the first tie goes to CPU.
